lzc_norm_sched: RTL and testbench

- Shares one 24-bit leading-zero counter and one left-shift normaliser between N_REQ requesters, e.g. the per-axis reciprocal front ends.
- Round-robin arbitration; valid/ready handshakes on every requester and on the result port.
- 2-stage pipeline (operand capture, then count+shift) feeding the reciprocal LUT/Newton stage with a normalised mantissa, shift count and requester ID.

---
 rtl/lzc_norm_pkg.sv | 42 ++++
 rtl/lzc24.sv | 34 +++
 rtl/rr_arb_onehot.sv | 49 ++++
 rtl/lzc_norm_sched.sv | 201 ++++++++++++++++++++
 tb/tb_lzc_norm_sched.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lzc_norm_pkg.sv
// ============================================================================
// lzc_norm_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the shared leading-zero-count / normalise
// scheduler (lzc_norm_sched) and its helpers (lzc24, rr_arb_onehot).
//
// Contents:
//   LZC_W        operand / mantissa width (24)
//   LZ_W         width of a leading-zero count (5, holds 0..24)
//   LZ_ALLZERO   count reported for an all-zero operand (24)
//   ID_MAX_W     widest requester ID the result record can carry (8 requesters)
//   STAT_W       width of the optional statistics counters
//   lzc_result_t one result record {id, lz, zero, norm}
//   sat_inc      saturating increment used by the statistics counters
//
// Optional feature macro used by the scheduler: LZC_NORM_STATS_EN.
// ============================================================================
package lzc_norm_pkg;

   localparam int LZC_W    = 24;
   localparam int LZ_W     = 5;
   localparam logic [LZ_W-1:0] LZ_ALLZERO = 5'd24;
   localparam int ID_MAX_W = 3;
   localparam int STAT_W   = 16;

   // One normalised result as it leaves the count+shift stage. The id field
   // is sized for the largest supported requester count; narrower
   // configurations zero-extend into it.
   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [LZ_W-1:0]     lz;
      logic                zero;
      logic [LZC_W-1:0]    norm;
   } lzc_result_t;

   // Counters stick at all-ones instead of wrapping so a long soak never
   // reports a misleadingly small number.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/lzc24.sv
// ============================================================================
// lzc24
// ----------------------------------------------------------------------------
// Purely combinational 24-bit leading-zero counter.
//
// Ports:
//   data   in  24  operand
//   count  out 5   number of zero bits above the most significant one;
//                  24 when the operand is all zeroes
//   zero   out 1   operand is all zeroes
// ============================================================================
module lzc24
   import lzc_norm_pkg::*;
(
   input  logic [LZC_W-1:0] data,
   output logic [LZ_W-1:0]  count,
   output logic             zero
);

   // Scan from the LSB upwards; the last set bit visited is the most
   // significant one, so its position wins. With no set bit the default
   // all-zero count stays in place.
   always_comb begin
      count = LZ_ALLZERO;
      for (int i = 0; i < LZC_W; i++) begin
         if (data[i]) begin
            count = LZ_W'(LZC_W - 1 - i);
         end
      end
   end

   assign zero = (data == '0);

endmodule

// File: rtl/rr_arb_onehot.sv
// ============================================================================
// rr_arb_onehot
// ----------------------------------------------------------------------------
// Combinational round-robin arbiter. The search begins one place after the
// pointer (wrapping at N), so the requester that last won has the lowest
// priority. The pointer itself is owned by the caller, which only moves it
// on a completed handshake.
//
// Parameters:
//   N      number of requesters
//   IDX_W  width of the pointer / encoded index (2**IDX_W >= N)
//
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  index of the most recent winner
//   grant  out N      one-hot grant, zero when nobody requests
//   idx    out IDX_W  encoded index of the grant, 0 when nobody requests
// ============================================================================
module rr_arb_onehot #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   // Walk the candidates in priority order (ptr+1, ptr+2, ... ptr+N mod N)
   // and take the first one that is requesting. The inner loop matches the
   // candidate number against constant indices so no variable bit-select is
   // needed on the request vector.
   always_comb begin
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               idx      = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/lzc_norm_sched.sv
// ============================================================================
// lzc_norm_sched
// ----------------------------------------------------------------------------
// Shares one 24-bit leading-zero counter and one left-shift normaliser among
// N_REQ requesters (for example the per-axis reciprocal front ends). A
// round-robin arbiter picks one requester per cycle; the chosen operand is
// captured in stage 1, counted and shifted on the way into stage 2, and
// stage 2 presents the normalised mantissa, shift count and requester ID to
// the downstream reciprocal LUT/Newton stage. Both stages are elastic, so a
// stalled consumer fills the pipe (two results held) before back-pressure
// reaches the requesters, and results always leave in grant order.
//
// Parameters:
//   N_REQ  number of requesters, 2..8
//   ID_W   requester ID width, 2**ID_W >= N_REQ
//
// Ports:
//   clk             in   1         rising-edge clock
//   reset           in   1         synchronous, active-high
//   req_valid       in   N_REQ     requester i has an operand
//   req_data        in   N_REQ*24  operand i in bits [24*i+23:24*i], unsigned
//   req_ready       out  N_REQ     one-hot or zero; transfer on valid&ready
//   out_valid       out  1         result valid
//   out_ready       in   1         consumer accepts the result
//   out_id          out  ID_W      requester index of the result
//   out_lz          out  5         leading-zero count, 0..24
//   out_zero        out  1         operand was all zeroes
//   out_norm        out  24        operand << out_lz; 0 when out_zero
//   stat_zero_cnt   out  16        (LZC_NORM_STATS_EN only) saturating count
//                                  of all-zero results accepted downstream
//   stat_stall_cnt  out  16        (LZC_NORM_STATS_EN only) saturating count
//                                  of cycles with out_valid & !out_ready
//
// Build option: define LZC_NORM_STATS_EN to add the two statistics outputs.
// ============================================================================
module lzc_norm_sched
   import lzc_norm_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*LZC_W-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ID_W-1:0]        out_id,
   output logic [LZ_W-1:0]        out_lz,
   output logic                   out_zero,
`ifdef LZC_NORM_STATS_EN
   output logic [STAT_W-1:0]      stat_zero_cnt,
   output logic [STAT_W-1:0]      stat_stall_cnt,
`endif
   output logic [LZC_W-1:0]       out_norm
);

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   logic              s1_valid;
   logic [LZC_W-1:0]  s1_data;
   logic [ID_W-1:0]   s1_id;
   logic [ID_W-1:0]   ptr;
   lzc_result_t       out_q;

   logic              s1_adv;
   logic              s2_adv;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_idx;
   logic [LZC_W-1:0]  grant_data;
   logic [LZ_W-1:0]   lz_count;
   logic              lz_zero;
   lzc_result_t       s2_next;

   // Each stage may load whenever it is empty or the stage after it is
   // moving, which lets both stages advance together with no bubble.
   assign s2_adv = !out_valid || out_ready;
   assign s1_adv = !s1_valid || s2_adv;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   rr_arb_onehot #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   // The grant only turns into a handshake when stage 1 can take it. Ready
   // is forced low during reset so nothing is accepted into a pipe that is
   // being cleared.
   assign req_ready = grant & {N_REQ{s1_adv && !reset}};

   // Select the granted operand. The grant is one-hot or zero, so OR-ing the
   // masked lanes together is a plain multiplexer.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            grant_data = grant_data | req_data[i*LZC_W +: LZC_W];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Count and shift between stage 1 and stage 2
   // ------------------------------------------------------------------------
   lzc24 u_lzc (
      .data  (s1_data),
      .count (lz_count),
      .zero  (lz_zero)
   );

   // Shifting a non-zero operand by its own leading-zero count leaves a one
   // in bit 23. The all-zero case is forced to zero explicitly rather than
   // relying on a 24-place shift to flush the word.
   always_comb begin
      s2_next      = '0;
      s2_next.id   = ID_MAX_W'(s1_id);
      s2_next.lz   = lz_count;
      s2_next.zero = lz_zero;
      s2_next.norm = lz_zero ? '0 : (s1_data << lz_count);
   end

   // ------------------------------------------------------------------------
   // Stage 1: capture the granted operand and its requester ID. The
   // round-robin pointer moves to the winner only when the handshake really
   // completes, so a requester that drops valid never steals a turn.
   // Reset leaves the pointer on the last requester so requester 0 comes
   // first.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_id    <= '0;
         ptr      <= ID_W'(N_REQ - 1);
      end else begin
         if (s1_adv) begin
            s1_valid <= |grant;
            s1_data  <= grant_data;
            s1_id    <= grant_idx;
         end
         if (|req_ready) begin
            ptr <= grant_idx;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: output registers. They reload from the count+shift result when
   // the consumer takes the current word (or there is none) and otherwise
   // hold every field stable while stalled.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_q     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         out_q     <= s2_next;
      end
   end

   assign out_id   = out_q.id[ID_W-1:0];
   assign out_lz   = out_q.lz;
   assign out_zero = out_q.zero;
   assign out_norm = out_q.norm;

   // Upper id bits of the result record are always zero in configurations
   // narrower than the widest supported one; fold them into a sink.
   logic unused_id_bits;
   assign unused_id_bits = ^out_q.id;

`ifdef LZC_NORM_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics: all-zero operands delivered downstream, and cycles where a
   // result was waiting on the consumer. Both saturate at all-ones.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_zero_cnt  <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (out_valid && out_ready && out_q.zero) begin
            stat_zero_cnt <= sat_inc(stat_zero_cnt);
         end
         if (out_valid && !out_ready) begin
            stat_stall_cnt <= sat_inc(stat_stall_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_lzc_norm_sched.sv
// ============================================================================
// tb_lzc_norm_sched
// ----------------------------------------------------------------------------
// Self-checking bench for lzc_norm_sched (N_REQ=2, ID_W=1). A negedge
// monitor keeps a reference model of the arbiter pointer and stage
// occupancy, pushes the expected result of every handshake into a queue and
// pops/compares it when the DUT delivers. A table of hand-computed operand
// vectors and a few directed sequences cover latency, alternation, stalls,
// reset while full and a requester dropping out.
// ============================================================================
module tb_lzc_norm_sched;
   import lzc_norm_pkg::*;

   localparam int N_REQ = 2;
   localparam int ID_W  = 1;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [4:0]      lz;
      logic            zero;
      logic [23:0]     norm;
   } exp_t;

   typedef struct {
      logic [23:0] data;
      logic [4:0]  lz;
      logic        zero;
      logic [23:0] norm;
   } vec_t;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [N_REQ-1:0]    req_valid = '0;
   logic [N_REQ*24-1:0] req_data = '0;
   logic [N_REQ-1:0]    req_ready;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [ID_W-1:0]     out_id;
   logic [4:0]          out_lz;
   logic                out_zero;
   logic [23:0]         out_norm;
`ifdef LZC_NORM_STATS_EN
   logic [15:0]         stat_zero_cnt;
   logic [15:0]         stat_stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   exp_t            sb_q[$];
   logic            m_s1 = 1'b0;
   logic            m_out = 1'b0;
   logic [ID_W-1:0] m_ptr = ID_W'(N_REQ - 1);
   logic            prev_stall = 1'b0;
   logic [ID_W-1:0] snap_id;
   logic [4:0]      snap_lz;
   logic            snap_zero;
   logic [23:0]     snap_norm;

   lzc_norm_sched #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_id         (out_id),
      .out_lz         (out_lz),
      .out_zero       (out_zero),
`ifdef LZC_NORM_STATS_EN
      .stat_zero_cnt  (stat_zero_cnt),
      .stat_stall_cnt (stat_stall_cnt),
`endif
      .out_norm       (out_norm)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [23:0] d0,
                                input logic [23:0] d1, input logic ordy);
      req_valid = v;
      req_data  = {d1, d0};
      out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus('0, 24'h0, 24'h0, 1'b1);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reference count/shift: walk down from the MSB looking for the first one.
   function automatic exp_t modelResult(input logic [ID_W-1:0] id, input logic [23:0] d);
      exp_t r;
      r.id   = id;
      r.lz   = 5'd24;
      r.zero = 1'b1;
      r.norm = '0;
      for (int b = 23; b >= 0; b--) begin
         if (d[b]) begin
            r.lz   = 5'(23 - b);
            r.zero = 1'b0;
            r.norm = d << (23 - b);
            break;
         end
      end
      return r;
   endfunction

   // Monitor and scoreboard, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin : monitor
      logic             s1adv;
      logic             s2adv;
      logic [N_REQ-1:0] exp_ready;
      int               w;
      exp_t             e;

      s2adv = !m_out || out_ready;
      s1adv = !m_s1 || s2adv;
      w = -1;
      for (int k = 1; k <= N_REQ; k++) begin
         int c;
         c = (int'(m_ptr) + k) % N_REQ;
         if (w < 0 && req_valid[c]) w = c;
      end
      exp_ready = '0;
      if (!reset && s1adv && w >= 0) exp_ready[w] = 1'b1;

      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("out_valid", 32'(out_valid), 32'(m_out));

      if (prev_stall) begin
         checkOutput("hold_id", 32'(out_id), 32'(snap_id));
         checkOutput("hold_lz", 32'(out_lz), 32'(snap_lz));
         checkOutput("hold_zero", 32'(out_zero), 32'(snap_zero));
         checkOutput("hold_norm", 32'(out_norm), 32'(snap_norm));
      end
      prev_stall = !reset && out_valid && !out_ready;
      snap_id    = out_id;
      snap_lz    = out_lz;
      snap_zero  = out_zero;
      snap_norm  = out_norm;

      if (reset) begin
         sb_q.delete();
         m_s1  = 1'b0;
         m_out = 1'b0;
         m_ptr = ID_W'(N_REQ - 1);
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checkOutput("sb_underflow", 32'(sb_q.size()), 32'(1));
            end else begin
               e = sb_q.pop_front();
               checkOutput("sb_id", 32'(out_id), 32'(e.id));
               checkOutput("sb_lz", 32'(out_lz), 32'(e.lz));
               checkOutput("sb_zero", 32'(out_zero), 32'(e.zero));
               checkOutput("sb_norm", 32'(out_norm), 32'(e.norm));
            end
         end
         if (exp_ready != '0) begin
            sb_q.push_back(modelResult(ID_W'(w), req_data[24*w +: 24]));
            m_ptr = ID_W'(w);
         end
         if (s2adv) m_out = m_s1;
         if (s1adv) m_s1 = (w >= 0);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   found;
      int   lat;
      int   hs;
      int   outs;

      vecs[0] = '{24'h000F00, 5'd12, 1'b0, 24'hF00000};
      vecs[1] = '{24'h800000, 5'd0,  1'b0, 24'h800000};
      vecs[2] = '{24'h000001, 5'd23, 1'b0, 24'h800000};
      vecs[3] = '{24'h000000, 5'd24, 1'b1, 24'h000000};
      vecs[4] = '{24'h400000, 5'd1,  1'b0, 24'h800000};
      vecs[5] = '{24'h123456, 5'd3,  1'b0, 24'h91A2B0};
      vecs[6] = '{24'h00ABCD, 5'd8,  1'b0, 24'hABCD00};
      vecs[7] = '{24'h0000FF, 5'd16, 1'b0, 24'hFF0000};
      vecs[8] = '{24'h7FFFFF, 5'd1,  1'b0, 24'hFFFFFE};
      vecs[9] = '{24'h000002, 5'd22, 1'b0, 24'h800000};

      $display("[TB] start");
      doReset();
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_norm", 32'(out_norm), 32'(0));
      checkOutput("rst_out_lz", 32'(out_lz), 32'(0));

      // Table: one operand at a time through requester 0
      for (int i = 0; i < 10; i++) begin
         applyStimulus(2'b01, vecs[i].data, 24'h0, 1'b1);
         tick();
         applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
         found = 0;
         lat   = -1;
         for (int k = 0; k < 6 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
               found = 1;
               lat   = k;
            end
         end
         checkOutput("tbl_latency", lat, 1);
         if (found != 0) begin
            checkOutput("tbl_id", 32'(out_id), 32'(0));
            checkOutput("tbl_lz", 32'(out_lz), 32'(vecs[i].lz));
            checkOutput("tbl_zero", 32'(out_zero), 32'(vecs[i].zero));
            checkOutput("tbl_norm", 32'(out_norm), 32'(vecs[i].norm));
         end
         tick();
      end
`ifdef LZC_NORM_STATS_EN
      checkOutput("stat_zero", 32'(stat_zero_cnt), 32'(1));
      checkOutput("stat_stall", 32'(stat_stall_cnt), 32'(0));
`endif

      // Both requesters streaming: ids and counts alternate every cycle
      doReset();
      applyStimulus(2'b11, 24'h800000, 24'h000001, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("alt_valid", 32'(out_valid), 32'(1));
         checkOutput("alt_id", 32'(out_id), 32'(i % 2));
         checkOutput("alt_lz", 32'(out_lz), (i % 2 == 1) ? 32'd23 : 32'd0);
      end

      // Stall with continuous requests: exactly two handshakes, then no ready
      tick();
      applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
      tick();
      tick();
      tick();
      applyStimulus(2'b11, 24'h000F00, 24'h000000, 1'b0);
      hs = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if ((req_valid & req_ready) != '0) hs++;
      end
      checkOutput("stall_hs", hs, 2);
      checkOutput("stall_ready", 32'(req_ready), 32'(0));

      // Reset with both stages full
      tick();
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rstfull_ready_in_reset", 32'(req_ready), 32'(0));
      tick();
      @(negedge clk);
      checkOutput("rstfull_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rstfull_ready", 32'(req_ready), 32'(0));
      tick();
      reset = 1'b0;
      applyStimulus(2'b11, 24'h800000, 24'h000001, 1'b1);
      @(negedge clk);
      checkOutput("rstfull_first_grant", 32'(req_ready), 32'(2'b01));

      // Fill the pipe, stall it, then drain: exactly two results in order
      tick();
      tick();
      applyStimulus(2'b11, 24'h800000, 24'h000001, 1'b0);
      tick();
      tick();
      tick();
      applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
      outs = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) outs++;
      end
      checkOutput("drain_cnt", outs, 2);

      // Requester 1 drops out: requester 0 granted back-to-back
      tick();
      applyStimulus(2'b11, 24'h123456, 24'h00ABCD, 1'b1);
      tick();
      tick();
      tick();
      applyStimulus(2'b01, 24'h123456, 24'h00ABCD, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("drop_ready", 32'(req_ready), 32'(2'b01));
      end
      tick();
      applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
      for (int i = 0; i < 4; i++) tick();

      // Random traffic and back-pressure, checked by the scoreboard
      for (int i = 0; i < 80; i++) begin
         applyStimulus(N_REQ'($urandom_range(0, 3)),
                       24'($urandom() >> $urandom_range(0, 31)),
                       24'($urandom() >> $urandom_range(0, 31)),
                       ($urandom_range(0, 3) != 0));
         tick();
      end
      applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("sb_empty", 32'(sb_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
